wb_stage: RTL and testbench

//  Write-back stage of the 16-bit five-stage pipeline. Sits between the MEM/WB boundary and
//  the register file write port (d / wr / w_en, written at posedge).

---
 rtl/mips16_pkg.sv | 17 +
 rtl/wb_align.sv | 17 +
 rtl/wb_stage.sv | 150 +++++++++++++++
 tb/tb_wb_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared types for the 16-bit five-stage pipeline.
// The lane encoding is common to MEM, WB and the register file.
package mips16_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] WEN_NONE = 2'b00;
  localparam logic [1:0] WEN_LO   = 2'b01;
  localparam logic [1:0] WEN_HI   = 2'b10;
  localparam logic [1:0] WEN_WORD = 2'b11;

  typedef enum logic {
    IDLE,
    WAIT_LD
  } wb_state_t;

endpackage

// File: rtl/wb_align.sv
// Write-back byte-lane alignment.
// Optional byte swap, then zero the lanes that are not enabled.
module wb_align
  import mips16_pkg::*;
(
  input  logic [WORD_W-1:0] x_i,
  input  logic              swap_i,
  input  logic [1:0]        wen_i,
  output logic [WORD_W-1:0] y_o
);

  logic [WORD_W-1:0] sw;

  assign sw  = swap_i ? {x_i[7:0], x_i[15:8]} : x_i;
  assign y_o = sw & {{8{wen_i[1]}}, {8{wen_i[0]}}};

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results, waits for load data,
// drives the register file write port and the forwarding bus.
module wb_stage
  import mips16_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [2:0]       mem_dest,
  input  logic [DW-1:0]    mem_alu,
  input  logic             mem_is_load,
  input  logic [1:0]       mem_wen,
  input  logic             mem_swap,
  input  logic             dmem_rvalid,
  input  logic [DW-1:0]    dmem_rdata,
  output logic [2:0]       rf_d,
  output logic [DW-1:0]    rf_wr,
  output logic [1:0]       rf_wen,
  output logic             fwd_valid,
  output logic [2:0]       fwd_d,
  output logic [DW-1:0]    fwd_data,
  output logic [1:0]       fwd_wen,
  output logic             err_timeout,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  wb_state_t state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [2:0] ld_dest_q, ld_dest_d;
  logic [1:0] ld_wen_q, ld_wen_d;
  logic ld_swap_q, ld_swap_d;
  logic [2:0] rf_d_q, rf_d_d;
  logic [DW-1:0] rf_wr_q, rf_wr_d;
  logic [1:0] rf_wen_q, rf_wen_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic xfer;
  logic idle;
  logic [DW-1:0] al_x, al_y;
  logic al_swap;
  logic [1:0] al_wen;

  assign idle = (state_q == IDLE);
  assign xfer = mem_valid & idle;

  // One aligner serves both paths; the FSM state picks the source.
  assign al_x    = idle ? mem_alu  : dmem_rdata;
  assign al_swap = idle ? mem_swap : ld_swap_q;
  assign al_wen  = idle ? mem_wen  : ld_wen_q;

  wb_align u_align (
    .x_i   (al_x),
    .swap_i(al_swap),
    .wen_i (al_wen),
    .y_o   (al_y)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_dest_d = ld_dest_q;
    ld_wen_d  = ld_wen_q;
    ld_swap_d = ld_swap_q;
    rf_d_d    = rf_d_q;
    rf_wr_d   = rf_wr_q;
    rf_wen_d  = WEN_NONE;
    err_d     = 1'b0;
    ret_d     = ret_q;
    if (xfer) begin
      ret_d = ret_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    unique case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (mem_is_load) begin
            ld_dest_d = mem_dest;
            ld_wen_d  = mem_wen;
            ld_swap_d = mem_swap;
            cnt_d     = '0;
            state_d   = WAIT_LD;
          end else begin
            rf_wen_d = mem_wen;
            rf_d_d   = mem_dest;
            rf_wr_d  = al_y;
          end
        end
      end
      WAIT_LD: begin
        if (dmem_rvalid) begin
          rf_wen_d = ld_wen_q;
          rf_d_d   = ld_dest_q;
          rf_wr_d  = al_y;
          state_d  = IDLE;
        end else if (cnt_q == TLAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_dest_q <= '0;
      ld_wen_q  <= WEN_NONE;
      ld_swap_q <= 1'b0;
      rf_d_q    <= '0;
      rf_wr_q   <= '0;
      rf_wen_q  <= WEN_NONE;
      err_q     <= 1'b0;
      ret_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_dest_q <= ld_dest_d;
      ld_wen_q  <= ld_wen_d;
      ld_swap_q <= ld_swap_d;
      rf_d_q    <= rf_d_d;
      rf_wr_q   <= rf_wr_d;
      rf_wen_q  <= rf_wen_d;
      err_q     <= err_d;
      ret_q     <= ret_d;
    end
  end

  assign mem_ready   = idle;
  assign rf_d        = rf_d_q;
  assign rf_wr       = rf_wr_q;
  assign rf_wen      = rf_wen_q;
  assign fwd_valid   = |rf_wen_q;
  assign fwd_d       = rf_d_q;
  assign fwd_data    = rf_wr_q;
  assign fwd_wen     = rf_wen_q;
  assign err_timeout = err_q;
  assign retire_cnt  = ret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU, loads, timeout,
// reset mid-load and retire counter wrap.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [2:0]  mem_dest;
  logic [15:0] mem_alu;
  logic        mem_is_load;
  logic [1:0]  mem_wen;
  logic        mem_swap;
  logic        dmem_rvalid;
  logic [15:0] dmem_rdata;

  logic        mem_ready, fwd_valid, err_timeout;
  logic [2:0]  rf_d, fwd_d;
  logic [15:0] rf_wr, fwd_data;
  logic [1:0]  rf_wen, fwd_wen;
  logic [15:0] retire_cnt;

  logic        b_ready, b_fv, b_err;
  logic [2:0]  b_d, b_fd;
  logic [15:0] b_wr, b_fdata;
  logic [1:0]  b_wen, b_fwen;
  logic [3:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  int pulses;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_dest(mem_dest), .mem_alu(mem_alu),
    .mem_is_load(mem_is_load), .mem_wen(mem_wen),
    .mem_swap(mem_swap),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_d(rf_d), .rf_wr(rf_wr), .rf_wen(rf_wen),
    .fwd_valid(fwd_valid), .fwd_d(fwd_d),
    .fwd_data(fwd_data), .fwd_wen(fwd_wen),
    .err_timeout(err_timeout), .retire_cnt(retire_cnt)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_ready(b_ready),
    .mem_dest(mem_dest), .mem_alu(mem_alu),
    .mem_is_load(mem_is_load), .mem_wen(mem_wen),
    .mem_swap(mem_swap),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .rf_d(b_d), .rf_wr(b_wr), .rf_wen(b_wen),
    .fwd_valid(b_fv), .fwd_d(b_fd),
    .fwd_data(b_fdata), .fwd_wen(b_fwen),
    .err_timeout(b_err), .retire_cnt(b_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [2:0] d, input logic [15:0] a,
                     input logic [1:0] w, input logic s);
    mem_valid = 1'b1; mem_is_load = 1'b0;
    mem_dest = d; mem_alu = a; mem_wen = w; mem_swap = s;
  endtask

  task automatic load(input logic [2:0] d, input logic [1:0] w,
                      input logic s);
    mem_valid = 1'b1; mem_is_load = 1'b1;
    mem_dest = d; mem_alu = 16'hDEAD; mem_wen = w; mem_swap = s;
  endtask

  task automatic idle_in();
    mem_valid = 1'b0; mem_is_load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_valid = 0; mem_dest = 0; mem_alu = 0; mem_is_load = 0;
    mem_wen = 0; mem_swap = 0; dmem_rvalid = 0; dmem_rdata = 0;
    tick();
    tick();
    chk("rst_wen", rf_wen, 2'b00);
    chk("rst_wr", rf_wr, 16'h0);
    chk("rst_d", rf_d, 3'd0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_cnt", retire_cnt, 16'd0);
    chk("rst_ready", mem_ready, 1'b1);
    rst_n = 1'b1;

    // ALU back-to-back
    alu(3'd1, 16'h1111, 2'b11, 1'b0);
    tick();
    chk("a1_wen", rf_wen, 2'b11);
    chk("a1_d", rf_d, 3'd1);
    chk("a1_wr", rf_wr, 16'h1111);
    chk("a1_ready", mem_ready, 1'b1);
    alu(3'd2, 16'h2222, 2'b11, 1'b0);
    tick();
    chk("a2_wen", rf_wen, 2'b11);
    chk("a2_d", rf_d, 3'd2);
    chk("a2_wr", rf_wr, 16'h2222);
    chk("a2_ready", mem_ready, 1'b1);
    alu(3'd3, 16'h3333, 2'b11, 1'b0);
    tick();
    chk("a3_wen", rf_wen, 2'b11);
    chk("a3_d", rf_d, 3'd3);
    chk("a3_wr", rf_wr, 16'h3333);
    chk("a3_fwd", {fwd_valid, fwd_d, fwd_data, fwd_wen},
        {1'b1, 3'd3, 16'h3333, 2'b11});
    idle_in();
    tick();
    chk("a_off_wen", rf_wen, 2'b00);
    chk("a_off_fv", fwd_valid, 1'b0);
    chk("a_cnt", retire_cnt, 16'd3);

    // load with a 4-cycle wait
    load(3'd5, 2'b11, 1'b0);
    tick();
    idle_in();
    chk("l_wen0", rf_wen, 2'b00);
    chk("l_ready0", mem_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l_wait_ready", mem_ready, 1'b0);
      chk("l_wait_wen", rf_wen, 2'b00);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 16'hBEEF;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = 16'h0;
    chk("l_wen", rf_wen, 2'b11);
    chk("l_d", rf_d, 3'd5);
    chk("l_wr", rf_wr, 16'hBEEF);
    chk("l_err", err_timeout, 1'b0);
    chk("l_ready", mem_ready, 1'b1);
    tick();
    chk("l_off_wen", rf_wen, 2'b00);
    chk("l_cnt", retire_cnt, 16'd4);

    // byte load into the high lane, then low-byte ALU
    load(3'd6, 2'b10, 1'b1);
    tick();
    idle_in();
    dmem_rvalid = 1'b1; dmem_rdata = 16'h00A5;
    tick();
    dmem_rvalid = 1'b0;
    chk("bh_wr", rf_wr, 16'hA500);
    chk("bh_wen", rf_wen, 2'b10);
    chk("bh_fdata", fwd_data, 16'hA500);
    alu(3'd7, 16'h12C3, 2'b01, 1'b0);
    tick();
    idle_in();
    chk("bl_wr", rf_wr, 16'h00C3);
    chk("bl_wen", rf_wen, 2'b01);
    chk("bl_d", rf_d, 3'd7);

    // timeout with no data
    load(3'd4, 2'b11, 1'b0);
    tick();
    idle_in();
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (err_timeout === 1'b1) pulses++;
      chk("to_wen", rf_wen, 2'b00);
    end
    chk("to_pulses", pulses, 1);
    chk("to_ready", mem_ready, 1'b1);
    chk("to_cnt", retire_cnt, 16'd7);

    // data on the last wait cycle wins over the timeout
    load(3'd3, 2'b11, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("tl_ready", mem_ready, 1'b0);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 16'h1234;
    tick();
    dmem_rvalid = 1'b0;
    chk("tl_wen", rf_wen, 2'b11);
    chk("tl_wr", rf_wr, 16'h1234);
    chk("tl_err", err_timeout, 1'b0);
    tick();
    chk("tl_err2", err_timeout, 1'b0);

    // reset mid-load
    alu(3'd1, 16'hABCD, 2'b11, 1'b0);
    tick();
    load(3'd2, 2'b11, 1'b0);
    tick();
    idle_in();
    tick();
    chk("rm_ready_pre", mem_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rm_ready", mem_ready, 1'b1);
    chk("rm_wr", rf_wr, 16'h0);
    chk("rm_d", rf_d, 3'd0);
    chk("rm_cnt", retire_cnt, 16'd0);
    #3;
    rst_n = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 16'h5555;
    tick();
    dmem_rvalid = 1'b0;
    chk("rm_late_wen", rf_wen, 2'b00);
    chk("rm_late_err", err_timeout, 1'b0);
    tick();
    chk("rm_late_wen2", rf_wen, 2'b00);

    // counter wrap on the 4-bit instance, wen 00 transfers
    for (int i = 0; i < 17; i++) begin
      alu(3'd0, 16'hFFFF, 2'b00, 1'b0);
      tick();
      chk("w_wen", rf_wen, 2'b00);
    end
    idle_in();
    tick();
    chk("w_cnt4", b_cnt, 4'd1);
    chk("w_cnt16", retire_cnt, 16'd17);

    // dest 0 is written like any other register
    alu(3'd0, 16'h0F0F, 2'b11, 1'b0);
    tick();
    idle_in();
    chk("r0_wen", rf_wen, 2'b11);
    chk("r0_wr", rf_wr, 16'h0F0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
